// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Registered program-counter unit for a single-cycle core. It owns the PC
// register, resolves the next PC from branch controls, and keeps a small
// return-address stack (RAS) for BL / RET.
//
// Ports
//   CLK, Reset            clock (rising edge), synchronous active-high reset
//   stall                 hold PC, RAS and flags this cycle
//   uncondBranch          B / BL: take pc + (imm << log2(INSTR_BYTES))
//   condBranch            CBZ/CBNZ: take the imm target if the condition holds
//   condInvert, ALUzero   condition select (0 = CBZ) and ALU zero flag
//   imm                   signed word offset
//   regBranch, regTarget  BR: jump to regTarget
//   link, ret             BL push / RET pop of the RAS
//   pc                    current PC (registered)
//   nextPC                combinational next PC (independent of stall)
//   rasEmpty              RAS holds no entries
//   rasOverflow           sticky: a push discarded the oldest entry
//   misalignFault         last PC update came from a misaligned target
//
// Build option
//   PC_ALIGN_CHECK_EN     when defined, a misaligned non-sequential target
//                         loads FAULT_VECTOR and raises misalignFault;
//                         otherwise the target low bits are cleared.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int               WIDTH        = 64,
    parameter int               INSTR_BYTES  = 4,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(64'h0),
    parameter logic [WIDTH-1:0] FAULT_VECTOR = WIDTH'(64'h100)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             stall,
    input  logic             uncondBranch,
    input  logic             condBranch,
    input  logic             condInvert,
    input  logic             ALUzero,
    input  logic [WIDTH-1:0] imm,
    input  logic             regBranch,
    input  logic [WIDTH-1:0] regTarget,
    input  logic             link,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] nextPC,
    output logic             rasEmpty,
    output logic             rasOverflow,
    output logic             misalignFault
);

    localparam int SHIFT = $clog2(INSTR_BYTES);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] ras_r [RAS_DEPTH];
    logic [PTR_W-1:0] top_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             mis_r;

    logic [WIDTH-1:0] seq_s;
    logic [WIDTH-1:0] tgt_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] next_s;
    logic [PTR_W-1:0] top_inc_s;
    logic             taken_s;
    logic             jump_s;
    logic             ras_has_s;
    logic             fault_s;
    logic             push_s;
    logic             pop_s;
    logic             swap_s;

    assign seq_s     = pc_r + WIDTH'(INSTR_BYTES);
    assign tgt_s     = pc_r + (imm << SHIFT);
    assign taken_s   = condBranch & (ALUzero ^ condInvert);
    assign ras_has_s = (cnt_r != {CNT_W{1'b0}});
    assign top_inc_s = top_r + PTR_W'(1);

    // RAS operation decode; link+ret together replaces the top in place
    assign push_s = link & ~ret;
    assign pop_s  = ret & ~link & ras_has_s;
    assign swap_s = link & ret;

    // Next-PC priority: ret > regBranch > uncondBranch > taken > sequential
    always_comb begin
        raw_s  = seq_s;
        jump_s = 1'b0;
        if (ret) begin
            jump_s = 1'b1;
            raw_s  = ras_has_s ? ras_r[top_r] : regTarget;
        end else if (regBranch) begin
            jump_s = 1'b1;
            raw_s  = regTarget;
        end else if (uncondBranch || taken_s) begin
            jump_s = 1'b1;
            raw_s  = tgt_s;
        end else begin
            jump_s = 1'b0;
            raw_s  = seq_s;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_s;
    assign misaligned_s = jump_s & ((raw_s & ALIGN_MASK) != {WIDTH{1'b0}});

    // Misaligned jump targets divert to the fault handler
    always_comb begin
        next_s  = raw_s;
        fault_s = 1'b0;
        if (misaligned_s) begin
            next_s  = FAULT_VECTOR;
            fault_s = 1'b1;
        end else begin
            next_s  = raw_s;
            fault_s = 1'b0;
        end
    end
`else
    // Jump targets are silently aligned down to an instruction boundary
    always_comb begin
        next_s  = seq_s;
        fault_s = 1'b0;
        if (jump_s) begin
            next_s = raw_s & ~ALIGN_MASK;
        end else begin
            next_s = seq_s;
        end
    end
`endif

    // PC, RAS and status registers; stall freezes everything
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_r  <= RESET_VECTOR;
            top_r <= {PTR_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
            mis_r <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= {WIDTH{1'b0}};
            end
        end else if (!stall) begin
            pc_r  <= next_s;
            mis_r <= fault_s;
            if (push_s) begin
                // Circular buffer: when full the new entry lands on the oldest
                ras_r[top_inc_s] <= seq_s;
                top_r            <= top_inc_s;
                if (cnt_r == CNT_FULL) begin
                    ovf_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else if (pop_s) begin
                cnt_r <= cnt_r - CNT_W'(1);
                top_r <= top_r - PTR_W'(1);
            end else if (swap_s) begin
                ras_r[top_r] <= seq_s;
                if (!ras_has_s) begin
                    cnt_r <= CNT_W'(1);
                end
            end
        end
    end

    assign pc            = pc_r;
    assign nextPC        = next_s;
    assign rasEmpty      = ~ras_has_s;
    assign rasOverflow   = ovf_r;
    assign misalignFault = mis_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer (default parameters). The driver pushes
// hand-computed expectations into a scoreboard queue tagged with the cycle
// they apply to; an independent monitor pops and compares at each negedge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, uncond, cond, cinv, zero, regb, link, ret;
    logic [63:0] imm, rtgt;
    logic [63:0] pc, next_pc;
    logic        ras_empty, ras_ovf, mis_fault;

    pc_sequencer dut (
        .CLK          (clk),
        .Reset        (rst),
        .stall        (stall),
        .uncondBranch (uncond),
        .condBranch   (cond),
        .condInvert   (cinv),
        .ALUzero      (zero),
        .imm          (imm),
        .regBranch    (regb),
        .regTarget    (rtgt),
        .link         (link),
        .ret          (ret),
        .pc           (pc),
        .nextPC       (next_pc),
        .rasEmpty     (ras_empty),
        .rasOverflow  (ras_ovf),
        .misalignFault(mis_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        bit          is_next;
        logic [63:0] val;
        logic        e_empty;
        logic        e_ovf;
        logic        e_mis;
    } exp_t;

    exp_t sb[$];
    int   cycle  = 0;
    int   total  = 0;
    int   passed = 0;
    logic exp_empty, exp_ovf, exp_mis;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: compare every expectation due by the current cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            e = sb.pop_front();
            if (e.cyc < cycle) begin
                total++;
                $display("FAIL %s: stale expectation for cycle %0d at cycle %0d", e.name, e.cyc, cycle);
            end else if (e.is_next) begin
                check(e.name, next_pc, e.val);
            end else begin
                check(e.name, pc, e.val);
                check({e.name, ".empty"}, {63'd0, ras_empty}, {63'd0, e.e_empty});
                check({e.name, ".ovf"},   {63'd0, ras_ovf},   {63'd0, e.e_ovf});
                check({e.name, ".mis"},   {63'd0, mis_fault}, {63'd0, e.e_mis});
            end
        end
    end

    // Issue one cycle: expect nextPC now and pc/flags after the edge
    task automatic step(input string nm, input logic [63:0] e_next, input logic [63:0] e_pc, input bit chk_next);
        exp_t e;
        if (chk_next) begin
            e.cyc = cycle; e.name = {nm, ".next"}; e.is_next = 1'b1; e.val = e_next;
            e.e_empty = 1'b0; e.e_ovf = 1'b0; e.e_mis = 1'b0;
            sb.push_back(e);
        end
        e.cyc = cycle + 1; e.name = nm; e.is_next = 1'b0; e.val = e_pc;
        e.e_empty = exp_empty; e.e_ovf = exp_ovf; e.e_mis = exp_mis;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        stall = 1'b0; uncond = 1'b0; cond = 1'b0; cinv = 1'b0; zero = 1'b0;
        regb = 1'b0; link = 1'b0; ret = 1'b0; imm = 64'd0; rtgt = 64'd0;
    endtask

    task automatic go(input logic [63:0] a);
        regb = 1'b1; rtgt = a;
        step("goto", a, a, 1'b1);
        regb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1; exp_empty = 1'b1; exp_ovf = 1'b0; exp_mis = 1'b0;
        // 1 reset and sequential run
        step("rst0", 64'h0, 64'h0, 1'b0);
        step("rst1", 64'h4, 64'h0, 1'b1);
        rst = 1'b0;
        step("seq4", 64'h4, 64'h4, 1'b1);
        step("seq8", 64'h8, 64'h8, 1'b1);

        // 2 unconditional branch forward / backward
        go(64'h1000);
        uncond = 1'b1; imm = 64'd4;
        step("b_fwd", 64'h1010, 64'h1010, 1'b1);
        imm = 64'hFFFF_FFFF_FFFF_FFFC;
        step("b_back", 64'h1000, 64'h1000, 1'b1);
        idle();

        // 3 CBZ / CBNZ
        go(64'h2000);
        cond = 1'b1; imm = 64'd4; cinv = 1'b0; zero = 1'b1;
        step("cbz_taken", 64'h2010, 64'h2010, 1'b1);
        go(64'h2000);
        zero = 1'b0;
        step("cbz_not", 64'h2004, 64'h2004, 1'b1);
        go(64'h2000);
        cinv = 1'b1; zero = 1'b0;
        step("cbnz_taken", 64'h2010, 64'h2010, 1'b1);
        zero = 1'b1;
        step("cbnz_not", 64'h2014, 64'h2014, 1'b1);
        idle();

        // 4 stall holds PC and RAS, then BL completes
        go(64'h3000);
        stall = 1'b1; uncond = 1'b1; imm = 64'd4; link = 1'b1;
        for (int i = 0; i < 3; i++) step("stall", 64'h3010, 64'h3000, 1'b1);
        stall = 1'b0; exp_empty = 1'b0;
        step("stall_rel", 64'h3010, 64'h3010, 1'b1);
        idle(); ret = 1'b1; exp_empty = 1'b1;
        step("stall_ret", 64'h3004, 64'h3004, 1'b1);
        idle();

        // 5 RAS push/pop, empty RET, overflow
        go(64'h4000);
        link = 1'b1; uncond = 1'b1; imm = 64'h10; exp_empty = 1'b0;
        step("bl", 64'h4040, 64'h4040, 1'b1);
        idle(); ret = 1'b1; exp_empty = 1'b1;
        step("ret", 64'h4004, 64'h4004, 1'b1);
        rtgt = 64'h5000;
        step("ret_empty", 64'h5000, 64'h5000, 1'b1);
        idle(); link = 1'b1; uncond = 1'b1; imm = 64'h10; exp_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) exp_ovf = 1'b1;
            step("push", 64'h5040 + 64'(i) * 64'h40, 64'h5040 + 64'(i) * 64'h40, 1'b1);
        end
        idle(); ret = 1'b1; rtgt = 64'h7000;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_empty = 1'b1;
            step("pop", 64'h5104 - 64'(i) * 64'h40, 64'h5104 - 64'(i) * 64'h40, 1'b1);
        end
        step("pop_reg", 64'h7000, 64'h7000, 1'b1);
        idle(); link = 1'b1; exp_empty = 1'b0;
        step("link_only", 64'h7004, 64'h7004, 1'b1);
        ret = 1'b1;
        step("swap", 64'h7004, 64'h7004, 1'b1);
        idle(); ret = 1'b1; exp_empty = 1'b1;
        step("ret_swap", 64'h7008, 64'h7008, 1'b1);
        idle();

        // 6 misaligned BR and wrap-around
        regb = 1'b1; rtgt = 64'h6002;
`ifdef PC_ALIGN_CHECK_EN
        exp_mis = 1'b1;
        step("br_mis", 64'h100, 64'h100, 1'b1);
        idle(); exp_mis = 1'b0;
        step("after_mis", 64'h104, 64'h104, 1'b1);
`else
        step("br_mis", 64'h6000, 64'h6000, 1'b1);
        idle();
        step("after_mis", 64'h6004, 64'h6004, 1'b1);
`endif
        go(64'hFFFF_FFFF_FFFF_FFFC);
        step("wrap", 64'h0, 64'h0, 1'b1);

        // Reset clears the sticky overflow
        rst = 1'b1; exp_empty = 1'b1; exp_ovf = 1'b0; exp_mis = 1'b0;
        step("rst_again", 64'h4, 64'h0, 1'b1);
        rst = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
